// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle MIPS core: sequences core reset,
// gates execution, counts cycles/instructions, detects halt and timeout.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          level request to begin a run (IDLE or DONE only)
//   pc, pc_valid   observed PC and its retire qualifier
//   cpu_reset      reset to the core (held in IDLE and RESET)
//   cpu_en         core clock-enable, high only while running
//   running, done  state flags
//   timeout        run ended because the cycle budget ran out
//   cycle_count    RUN cycles in current/last run (saturating)
//   instr_count    retired instructions in current/last run (saturating)
module cpu_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 4,
  parameter int HALT_REPEAT = 3,
  parameter int MAX_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } state_t;

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int HR_W = $clog2(HALT_REPEAT + 1);

  localparam logic [RC_W-1:0] RST_LAST =
    RC_W'(RST_CYCLES - 1);
  localparam logic [HR_W-1:0] HALT_N =
    HR_W'(HALT_REPEAT);
  localparam logic [HR_W-1:0] REP_ONE =
    HR_W'(1);
  localparam logic [CNT_W-1:0] CYC_LAST =
    CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t            state;
  logic [RC_W-1:0]   rst_cnt;
  logic [PC_W-1:0]   last_pc;
  logic              last_pc_valid;
  logic [HR_W-1:0]   rep;

  logic              pc_same;
  logic [HR_W-1:0]   rep_next;
  logic              halt_hit;
  logic              budget_hit;
  logic [CNT_W-1:0]  cyc_inc;
  logic [CNT_W-1:0]  ins_inc;

  // The repeat count never exceeds HALT_REPEAT-1 while in RUN, because
  // reaching HALT_REPEAT leaves RUN, so rep+1 cannot overflow HR_W.
  always_comb begin
    pc_same    = last_pc_valid && (pc == last_pc);
    rep_next   = pc_same ? rep + REP_ONE : REP_ONE;
    halt_hit   = pc_valid && (rep_next == HALT_N);
    budget_hit = (cycle_count == CYC_LAST);
    cyc_inc    = (cycle_count == CNT_SAT) ?
                 cycle_count : cycle_count + CNT_ONE;
    ins_inc    = (instr_count == CNT_SAT) ?
                 instr_count : instr_count + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cpu_reset     <= 1'b1;
      cpu_en        <= 1'b0;
      running       <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      cycle_count   <= '0;
      instr_count   <= '0;
      rst_cnt       <= '0;
      last_pc       <= '0;
      last_pc_valid <= 1'b0;
      rep           <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RESET;
            cpu_reset     <= 1'b1;
            cpu_en        <= 1'b0;
            running       <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            cycle_count   <= '0;
            instr_count   <= '0;
            rst_cnt       <= RST_LAST;
            last_pc_valid <= 1'b0;
            rep           <= '0;
          end
        end
        RESET: begin
          if (rst_cnt == '0) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            cpu_en    <= 1'b1;
            running   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          cycle_count <= cyc_inc;
          if (pc_valid) begin
            instr_count   <= ins_inc;
            rep           <= rep_next;
            last_pc       <= pc;
            last_pc_valid <= 1'b1;
          end
          // Halt takes priority over a budget expiring the same cycle.
          if (halt_hit || budget_hit) begin
            state     <= DONE;
            cpu_reset <= 1'b0;
            cpu_en    <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b1;
            timeout   <= !halt_hit;
          end
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          cpu_en    <= 1'b0;
          running   <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
